time_set_parser: RTL and testbench

Receives ASCII bytes from the board UART receiver, parses a time-set frame `T HH MM SS <CR|LF>`, range-checks it, and issues a one-cycle load of a packed 24-bit time word into the watch datapath. It is the write side of the watch time registers: the watch counts and displays that word, and this block sets it from a host.

---
 rtl/time_pkg.sv | 77 +++++++
 rtl/frame_timeout.sv | 47 ++++
 rtl/time_set_parser.sv | 233 +++++++++++++++++++++++
 tb/tb_time_set_parser.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// ----------------------------------------------------------------------------
// time_pkg
// Shared definitions for the watch time registers: ASCII codes used by the
// time-set frame parser, the parser state encoding, packed time word field
// positions, the reset time and small arithmetic helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package time_pkg;

    // ASCII characters recognised in a time-set frame
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_t  = 8'h74;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_2  = 8'h32;
    localparam logic [7:0] CH_5  = 8'h35;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Parser states, one per expected byte position of "T HH MM SS <term>"
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_H10  = 3'd1,
        ST_H1   = 3'd2,
        ST_M10  = 3'd3,
        ST_M1   = 3'd4,
        ST_S10  = 3'd5,
        ST_S1   = 3'd6,
        ST_TERM = 3'd7
    } parser_state_e;

    // Packed time word layout
    localparam int HOUR_MSB = 23;
    localparam int HOUR_LSB = 19;
    localparam int MIN_MSB  = 18;
    localparam int MIN_LSB  = 13;
    localparam int SEC_MSB  = 12;
    localparam int SEC_LSB  = 7;
    localparam int MSEC_MSB = 6;
    localparam int MSEC_LSB = 0;

    localparam int TIME_W   = HOUR_MSB + 1;

    // Hour shown after reset; the watch datapath uses the same value
    localparam logic [4:0] RESET_HOUR = 5'd12;
    localparam logic [4:0] MAX_HOUR   = 5'd23;

    localparam logic [TIME_W-1:0] RESET_TIME = {RESET_HOUR, 6'd0, 6'd0, 7'd0};

    // Tens digit times ten as shift-and-add, hour width
    function automatic logic [4:0] times_ten_5(input logic [3:0] d);
        logic [4:0] w;
        w = {1'b0, d};
        return (w << 3) + (w << 1);
    endfunction

    // Tens digit times ten as shift-and-add, minute/second width
    function automatic logic [5:0] times_ten_6(input logic [3:0] d);
        logic [5:0] w;
        w = {2'b00, d};
        return (w << 3) + (w << 1);
    endfunction

    // Assemble the packed time word; milliseconds are always zero on a set
    function automatic logic [TIME_W-1:0] pack_time(input logic [4:0] hour,
                                                    input logic [5:0] min,
                                                    input logic [5:0] sec);
        logic [TIME_W-1:0] t;
        t = '0;
        t[HOUR_MSB:HOUR_LSB] = hour;
        t[MIN_MSB:MIN_LSB]   = min;
        t[SEC_MSB:SEC_LSB]   = sec;
        t[MSEC_MSB:MSEC_LSB] = 7'd0;
        return t;
    endfunction

endpackage

// File: rtl/frame_timeout.sv
// ----------------------------------------------------------------------------
// frame_timeout
// Inter-byte timeout for the time-set frame parser. Counts clock cycles while
// a frame is open and flags when TIMEOUT_CYCLES cycles pass without a byte.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   enable   count while high (frame in progress)
//   clear    a byte arrived this cycle; restart the count
//   expired  one-cycle pulse: terminal count reached with no byte this cycle
// ----------------------------------------------------------------------------
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A byte on the terminal cycle takes priority, so clear masks expiry
    assign expired = enable && !clear && (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || !enable || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_parser.sv
// ----------------------------------------------------------------------------
// time_set_parser
// Parses ASCII time-set frames "T HH MM SS <CR|LF>" from the UART receiver,
// range-checks the hour and issues a one-cycle load of the packed time word
// into the watch datapath. Malformed, out-of-range or timed-out frames give a
// one-cycle error pulse and leave the loaded time untouched.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_rx_data    received byte, qualified by i_rx_valid
//   i_rx_valid   one-cycle strobe per received byte
//   o_load       one-cycle load pulse, o_load_time valid in the same cycle
//   o_load_time  packed time {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
//   o_error      one-cycle pulse on a rejected frame
//   o_busy       frame in progress
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for 'T'/'t'; other bytes ignored
// H10     | expecting hour tens digit '0'..'2'
// H1      | expecting hour units digit '0'..'9'
// M10     | expecting minute tens digit '0'..'5'
// M1      | expecting minute units digit '0'..'9'
// S10     | expecting second tens digit '0'..'5'
// S1      | expecting second units digit '0'..'9'
// TERM    | expecting CR or LF; hour range check, then load
// ----------------------------------------------------------------------------
module time_set_parser
    import time_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_load,
    output logic [TIME_W-1:0]  o_load_time,
    output logic               o_error,
    output logic               o_busy
);

    parser_state_e     state_q, state_d;
    logic [3:0]        h10_q, h10_d;
    logic [3:0]        h1_q,  h1_d;
    logic [3:0]        m10_q, m10_d;
    logic [3:0]        m1_q,  m1_d;
    logic [3:0]        s10_q, s10_d;
    logic [3:0]        s1_q,  s1_d;
    logic              load_q, load_d;
    logic              error_q, error_d;
    logic [TIME_W-1:0] load_time_q, load_time_d;

    logic              is_start;
    logic              is_digit;
    logic              is_term;
    logic [3:0]        digit_val;
    logic              bad_byte;
    logic              tmo_expired;

    logic [4:0]        hour_w;
    logic [5:0]        min_w;
    logic [5:0]        sec_w;
    logic              hour_ok;

    // ------------------------------------------------------------------
    // Byte classification
    // ------------------------------------------------------------------
    assign is_start = (i_rx_data == CH_T) || (i_rx_data == CH_t);
    assign is_digit = (i_rx_data >= CH_0) && (i_rx_data <= CH_9);
    assign is_term  = (i_rx_data == CH_CR) || (i_rx_data == CH_LF);

    // For '0'..'9' the low nibble equals byte - 0x30; only used when is_digit
    assign digit_val = i_rx_data[3:0];

    // ------------------------------------------------------------------
    // Field assembly and range check (digits are stable by TERM)
    // ------------------------------------------------------------------
    assign hour_w  = times_ten_5(h10_q) + {1'b0, h1_q};
    assign min_w   = times_ten_6(m10_q) + {2'b00, m1_q};
    assign sec_w   = times_ten_6(s10_q) + {2'b00, s1_q};
    assign hour_ok = (hour_w <= MAX_HOUR);

    // ------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------
    frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q != ST_IDLE),
        .clear   (i_rx_valid),
        .expired (tmo_expired)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        h10_d       = h10_q;
        h1_d        = h1_q;
        m10_d       = m10_q;
        m1_d        = m1_q;
        s10_d       = s10_q;
        s1_d        = s1_q;
        load_d      = 1'b0;
        error_d     = 1'b0;
        load_time_d = load_time_q;
        bad_byte    = 1'b0;

        if (i_rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_start) begin
                        state_d = ST_H10;
                    end
                end
                ST_H10: begin
                    if (is_digit && (i_rx_data <= CH_2)) begin
                        h10_d   = digit_val;
                        state_d = ST_H1;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_H1: begin
                    if (is_digit) begin
                        h1_d    = digit_val;
                        state_d = ST_M10;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_M10: begin
                    if (is_digit && (i_rx_data <= CH_5)) begin
                        m10_d   = digit_val;
                        state_d = ST_M1;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_M1: begin
                    if (is_digit) begin
                        m1_d    = digit_val;
                        state_d = ST_S10;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_S10: begin
                    if (is_digit && (i_rx_data <= CH_5)) begin
                        s10_d   = digit_val;
                        state_d = ST_S1;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_S1: begin
                    if (is_digit) begin
                        s1_d    = digit_val;
                        state_d = ST_TERM;
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                ST_TERM: begin
                    if (is_term) begin
                        state_d = ST_IDLE;
                        // Hour tens up to '2' still lets 24..29 through
                        if (hour_ok) begin
                            load_d      = 1'b1;
                            load_time_d = pack_time(hour_w, min_w, sec_w);
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        bad_byte = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A start character inside a frame aborts it and opens a new one
            if (bad_byte) begin
                error_d = 1'b1;
                state_d = is_start ? ST_H10 : ST_IDLE;
            end
        end else if (tmo_expired) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            h10_q       <= '0;
            h1_q        <= '0;
            m10_q       <= '0;
            m1_q        <= '0;
            s10_q       <= '0;
            s1_q        <= '0;
            load_q      <= 1'b0;
            error_q     <= 1'b0;
            load_time_q <= RESET_TIME;
        end else begin
            state_q     <= state_d;
            h10_q       <= h10_d;
            h1_q        <= h1_d;
            m10_q       <= m10_d;
            m1_q        <= m1_d;
            s10_q       <= s10_d;
            s1_q        <= s1_d;
            load_q      <= load_d;
            error_q     <= error_d;
            load_time_q <= load_time_d;
        end
    end

    assign o_load      = load_q;
    assign o_error     = error_q;
    assign o_load_time = load_time_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_time_set_parser.sv
module tb_time_set_parser;

    localparam int TMO = 16;
    localparam logic [23:0] RESET_T = 24'(12 * 524288);

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        o_load;
    logic [23:0] o_load_time;
    logic        o_error;
    logic        o_busy;

    time_set_parser #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_load      (o_load),
        .o_load_time (o_load_time),
        .o_error     (o_error),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    longint cycle_cnt = 0;
    always @(posedge clk) cycle_cnt++;

    typedef struct {
        bit          is_load;
        logic [23:0] t;
        longint      due;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position within frame (0 = idle, 1..6 digits, 7 = terminator)
    int          pos;
    int          dig[6];
    int          gap;
    logic [23:0] last_time;

    function automatic logic [23:0] mk_time(input int h, input int m, input int s);
        return 24'(h * 524288 + m * 8192 + s * 128);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cycle_cnt);
        end
    endtask

    task automatic push_exp(input bit is_load, input logic [23:0] t);
        exp_t e;
        e.is_load = is_load;
        e.t       = t;
        e.due     = cycle_cnt + 1;
        expq.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int  lim[6];
        bit  st;
        int  h, m, s;
        lim = '{2, 9, 5, 9, 5, 9};
        st  = (b == 8'h54) || (b == 8'h74);
        gap = 0;
        if (pos == 0) begin
            if (st) pos = 1;
        end else if (pos <= 6) begin
            if (int'(b) >= 48 && int'(b) <= 48 + lim[pos-1]) begin
                dig[pos-1] = int'(b) - 48;
                pos++;
            end else begin
                push_exp(1'b0, last_time);
                pos = st ? 1 : 0;
            end
        end else begin
            if (b == 8'h0D || b == 8'h0A) begin
                h = dig[0] * 10 + dig[1];
                m = dig[2] * 10 + dig[3];
                s = dig[4] * 10 + dig[5];
                if (h < 24) begin
                    last_time = mk_time(h, m, s);
                    push_exp(1'b1, last_time);
                end else begin
                    push_exp(1'b0, last_time);
                end
                pos = 0;
            end else begin
                push_exp(1'b0, last_time);
                pos = st ? 1 : 0;
            end
        end
    endtask

    task automatic model_idle();
        if (pos != 0) begin
            gap++;
            if (gap >= TMO) begin
                push_exp(1'b0, last_time);
                pos = 0;
                gap = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("busy", 32'(o_busy), 32'(pos != 0));
        check("load_time", 32'(o_load_time), 32'(last_time));
    endtask

    task automatic cycle(input bit v, input logic [7:0] b);
        @(negedge clk);
        check_outputs();
        reset    = 1'b0;
        rx_valid = v;
        rx_data  = v ? b : 8'h00;
        if (v) model_byte(b);
        else   model_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        pos       = 0;
        gap       = 0;
        last_time = RESET_T;
    endtask

    task automatic random_frame();
        logic [7:0] fr[$];
        int         g, r;
        fr.delete();
        if ($urandom_range(0, 9) == 0) fr.push_back(8'($urandom_range(0, 255)));
        fr.push_back($urandom_range(0, 1) ? 8'h54 : 8'h74);
        fr.push_back(8'(48 + $urandom_range(0, 2)));
        fr.push_back(8'(48 + $urandom_range(0, 9)));
        fr.push_back(8'(48 + $urandom_range(0, 5)));
        fr.push_back(8'(48 + $urandom_range(0, 9)));
        fr.push_back(8'(48 + $urandom_range(0, 5)));
        fr.push_back(8'(48 + $urandom_range(0, 9)));
        fr.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        if ($urandom_range(0, 5) == 0) fr[$urandom_range(1, fr.size() - 1)] = 8'($urandom_range(0, 255));
        for (int i = 0; i < fr.size(); i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      g = 0;
            else if (r < 95) g = $urandom_range(1, 3);
            else             g = $urandom_range(TMO - 2, TMO + 1);
            idle(g);
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(1'b1, fr[i]);
        end
    endtask

    // Monitor: pops the expected event whenever the DUT pulses load or error
    always @(negedge clk) begin
        if (o_load === 1'b1 && o_error === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL load_and_error: both high at cycle %0d", cycle_cnt);
        end
        if (o_load === 1'b1 || o_error === 1'b1) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got load=%0b error=%0b time=%h at cycle %0d, expected no pulse",
                         o_load, o_error, o_load_time, cycle_cnt);
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.is_load !== o_load || mon_e.due != cycle_cnt ||
                    (mon_e.is_load && o_load_time !== mon_e.t)) begin
                    miscompares++;
                    $display("FAIL pulse: got load=%0b time=%h cycle=%0d, expected load=%0b time=%h cycle=%0d",
                             o_load, o_load_time, cycle_cnt, mon_e.is_load, mon_e.t, mon_e.due);
                end
            end
        end else if (expq.size() != 0 && expq[0].due <= cycle_cnt) begin
            vectors++;
            miscompares++;
            mon_e = expq.pop_front();
            $display("FAIL missed_pulse: got no pulse at cycle %0d, expected load=%0b time=%h",
                     cycle_cnt, mon_e.is_load, mon_e.t);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        pos       = 0;
        gap       = 0;
        last_time = RESET_T;
        for (int i = 0; i < 6; i++) dig[i] = 0;
        repeat (2) @(posedge clk);

        check("reset_load", 32'(o_load), 32'd0);
        check("reset_error", 32'(o_error), 32'd0);

        send_str("T123456\r");
        idle(3);
        send_str("T235959\n");
        send_str("T240000\r");
        idle(2);
        send_str("T12A");
        idle(2);
        send_str("T12T083000\r");
        idle(2);

        send_str("T1");
        idle(TMO + 2);
        send_str("T1");
        idle(TMO - 1);
        send_str("23456\r");
        idle(2);

        send_str("xyz\r");
        idle(3);
        send_str("T1234");
        do_reset();
        idle(1);
        send_str("T071530\r");
        idle(3);

        for (int f = 0; f < 300; f++) random_frame();

        idle(TMO + 4);
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
